// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed 7-segment display driver.
//
// Contents:
//   - seg_bit_e  : bit positions inside the 8-bit active-low segment word
//                  {dp,a,f,b,g,e,c,d} (bit7..bit0)
//   - SEG_0..SEG_9, SEG_A..SEG_F : active-low glyphs with dp off
//   - SEG_BLANK / SEG_ERR        : all segments off / error glyph (dp only)
//   - seg_apply_dp()             : lights the decimal point on a glyph
package seg_pkg;

    typedef enum int unsigned {
        SEG_BIT_D  = 0,
        SEG_BIT_C  = 1,
        SEG_BIT_E  = 2,
        SEG_BIT_G  = 3,
        SEG_BIT_B  = 4,
        SEG_BIT_F  = 5,
        SEG_BIT_A  = 6,
        SEG_BIT_DP = 7
    } seg_bit_e;

    localparam logic [7:0] SEG_0 = 8'h88;
    localparam logic [7:0] SEG_1 = 8'hED;
    localparam logic [7:0] SEG_2 = 8'hA2;
    localparam logic [7:0] SEG_3 = 8'hA4;
    localparam logic [7:0] SEG_4 = 8'hC5;
    localparam logic [7:0] SEG_5 = 8'h94;
    localparam logic [7:0] SEG_6 = 8'h90;
    localparam logic [7:0] SEG_7 = 8'hAD;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h84;
    localparam logic [7:0] SEG_A = 8'h81;
    localparam logic [7:0] SEG_B = 8'hD0;
    localparam logic [7:0] SEG_C = 8'h9A;
    localparam logic [7:0] SEG_D = 8'hE0;
    localparam logic [7:0] SEG_E = 8'h92;
    localparam logic [7:0] SEG_F = 8'h93;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ERR   = 8'h7F;

    // Segments are active-low, so lighting the dp clears its bit.
    function automatic logic [7:0] seg_apply_dp(input logic [7:0] glyph,
                                                input logic       dp);
        logic [7:0] r;
        r = glyph;
        if (dp) begin
            r[SEG_BIT_DP] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: combinational 4-bit code + decimal point -> active-low glyph.
//
// Ports:
//   code_i  [3:0] : digit code (BCD 0..9; 10..15 per build option)
//   dp_i          : 1 = decimal point lit
//   glyph_o [7:0] : active-low segments {dp,a,f,b,g,e,c,d}
//
// Build option SEG_HEX_GLYPHS_EN: when defined, codes 10..15 render the hex
// letters A b C d E F; otherwise they render the SEG_ERR glyph.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       dp_i,
    output logic [7:0] glyph_o
);

    logic [7:0] base;

    always_comb begin
        base = SEG_ERR;
        unique case (code_i)
            4'd0:    base = SEG_0;
            4'd1:    base = SEG_1;
            4'd2:    base = SEG_2;
            4'd3:    base = SEG_3;
            4'd4:    base = SEG_4;
            4'd5:    base = SEG_5;
            4'd6:    base = SEG_6;
            4'd7:    base = SEG_7;
            4'd8:    base = SEG_8;
            4'd9:    base = SEG_9;
`ifdef SEG_HEX_GLYPHS_EN
            4'd10:   base = SEG_A;
            4'd11:   base = SEG_B;
            4'd12:   base = SEG_C;
            4'd13:   base = SEG_D;
            4'd14:   base = SEG_E;
            4'd15:   base = SEG_F;
`else
            default: base = SEG_ERR;
`endif
        endcase
    end

    assign glyph_o = seg_apply_dp(base, dp_i);

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an N-digit common-anode
// 7-segment display with double-buffered data, leading-zero blanking and an
// anti-ghosting guard interval at the start of every digit slot.
//
// Parameters:
//   NUM_DIGITS   : digits scanned (1..16)
//   REFRESH_DIV  : clock cycles per digit slot (>= 2)
//   GUARD_CYCLES : cycles at slot start with all anodes off (< REFRESH_DIV)
//
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   enable     : 1 = scan; 0 = display dark, counters held at 0
//   load       : one-cycle strobe capturing digits_in / dp_in
//   digits_in  : packed BCD, nibble i = digit i (digit 0 rightmost)
//   dp_in      : per-digit decimal point, 1 = lit
//   blank_lz   : 1 = blank leading zeros
//   seg        : active-low segments {dp,a,f,b,g,e,c,d} (registered)
//   an         : active-low anodes, an[i] drives digit i (registered)
//   frame_done : one-cycle pulse after the digit index wraps (registered)
//
// Build option SEG_HEX_GLYPHS_EN (see seg_glyph_rom): hex glyphs for 10..15.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Scan counters
    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;

    // Double buffer
    logic [4*NUM_DIGITS-1:0]   pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0]   act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;

    // Registered pins
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      fdone_q, fdone_d;

    // Combinational helpers
    logic                      tick;
    logic                      boundary;
    logic [NUM_DIGITS-1:0]     zero_from;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_zero;
    logic [NUM_DIGITS-1:0]     an_lit;
    logic [7:0]                glyph;

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!enable) begin
            presc_d = '0;
            idx_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = boundary ? '0 : idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. Every load is captured into pending, so "pending" is
    // always the newest data. Whenever active must take new data (disabled,
    // or a boundary with a load or a waiting update) it copies pending_d,
    // which covers both the load-bypass and the pending->active transfer.
    // ------------------------------------------------------------------
    always_comb begin
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;

        if (load) begin
            pend_dig_d = digits_in;
            pend_dp_d  = dp_in;
        end

        if (!enable || (boundary && (load || pend_vld_q))) begin
            act_dig_d  = pend_dig_d;
            act_dp_d   = pend_dp_d;
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // zero_from[i] = nibbles i..NUM_DIGITS-1 of the active word are all 0
    // ------------------------------------------------------------------
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            run = run && (act_dig_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            zero_from[NUM_DIGITS-1-k] = run;
        end
    end

    // ------------------------------------------------------------------
    // Current-digit selection and anode pattern
    // ------------------------------------------------------------------
    always_comb begin
        cur_nib  = 4'd0;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        an_lit   = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = act_dig_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_zero  = zero_from[i];
                an_lit[i] = 1'b0;
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .code_i  (cur_nib),
        .dp_i    (cur_dp),
        .glyph_o (glyph)
    );

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        seg_d   = SEG_BLANK;
        an_d    = '1;
        fdone_d = 1'b0;
        if (enable) begin
            // Digit 0 is never blanked so a zero value still shows "0".
            if (blank_lz && (idx_q != '0) && cur_zero) begin
                seg_d = seg_apply_dp(SEG_BLANK, cur_dp);
            end else begin
                seg_d = glyph;
            end
            // seg keeps tracking the digit during guard; only anodes go dark.
            an_d    = (presc_q < GUARD_END) ? '1 : an_lit;
            fdone_d = boundary;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            act_dig_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
            fdone_q    <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            fdone_q    <= fdone_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int unsigned N     = 4;
    localparam int unsigned DIV   = 8;
    localparam int unsigned G     = 2;
    localparam int unsigned FRAME = N * DIV;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            enable = 1'b0;
    logic            load = 1'b0;
    logic [4*N-1:0]  digits_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic            blank_lz = 1'b0;
    logic [7:0]      seg;
    logic [N-1:0]    an;
    logic            frame_done;

    int unsigned checks = 0;
    int unsigned failures = 0;

    seg_scan_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]   seg;
        logic [N-1:0] an;
        logic         fd;
    } pins_t;

    pins_t       expq[$];
    int unsigned cnt = 0;          // enabled cycles since start of scanning
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pdp = '0;
    bit          m_pv = 0;
    logic [15:0] m_act = '0;
    logic [3:0]  m_adp = '0;

    function automatic logic [7:0] exp_glyph(input int unsigned v, input bit dp);
        logic [7:0] g;
        case (v)
            0: g = 8'h88;  1: g = 8'hED;  2: g = 8'hA2;  3: g = 8'hA4;
            4: g = 8'hC5;  5: g = 8'h94;  6: g = 8'h90;  7: g = 8'hAD;
            8: g = 8'h80;  9: g = 8'h84;
`ifdef SEG_HEX_GLYPHS_EN
            10: g = 8'h81; 11: g = 8'hD0; 12: g = 8'h9A;
            13: g = 8'hE0; 14: g = 8'h92; default: g = 8'h93;
`else
            default: g = 8'h7F;
`endif
        endcase
        if (dp) g[7] = 1'b0;
        return g;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expq.delete();
            cnt = 0; m_pend = '0; m_pdp = '0; m_pv = 0; m_act = '0; m_adp = '0;
        end else begin
            pins_t e;
            if (!enable) begin
                e = '{seg: 8'hFF, an: '1, fd: 1'b0};
                if (load) begin m_pend = digits_in; m_pdp = dp_in; end
                m_act = m_pend; m_adp = m_pdp; m_pv = 0; cnt = 0;
            end else begin
                int unsigned pos, s, ph;
                bit bnd, blank;
                pos   = cnt % FRAME;
                s     = pos / DIV;
                ph    = pos % DIV;
                bnd   = (pos == FRAME - 1);
                blank = blank_lz && (s > 0) && ((m_act >> (4 * s)) == 16'd0);
                e.seg = blank ? (m_adp[s] ? 8'h7F : 8'hFF)
                              : exp_glyph(int'((m_act >> (4 * s)) & 16'hF), m_adp[s]);
                e.an  = (ph < G) ? '1 : ~(4'b0001 << s);
                e.fd  = bnd;
                if (load) begin m_pend = digits_in; m_pdp = dp_in; end
                if (bnd && (load || m_pv)) begin
                    m_act = m_pend; m_adp = m_pdp; m_pv = 0;
                end else if (load) begin
                    m_pv = 1;
                end
                cnt++;
            end
            expq.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if ({seg, an, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL reset_state t=%0t got seg=%h an=%b fd=%b want seg=ff an=1111 fd=0",
                         $time, seg, an, frame_done);
            end
        end else if (expq.size() > 0) begin
            pins_t e;
            e = expq.pop_front();
            checks++;
            if ({seg, an, frame_done} !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got seg=%h an=%b fd=%b want seg=%h an=%b fd=%b",
                         $time, seg, an, frame_done, e.seg, e.an, e.fd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d; dp_in = p; load = 1'b1;
        cycles(1);
        load = 1'b0;
    endtask

    // Leaves the bench so that the next sampled edge is at frame position p.
    task automatic wait_pos(input int unsigned p);
        int unsigned n;
        n = 0;
        while ((cnt % FRAME) != p && n < 2 * FRAME) begin
            cycles(1);
            n++;
        end
        checks++;
        if ((cnt % FRAME) != p) begin
            failures++;
            $display("FAIL wait_pos timeout got=%0d want=%0d", cnt % FRAME, p);
        end
    endtask

    initial begin
        cycles(3);
        #3 rst_n = 1'b1;
        cycles(1);

        // load while disabled goes straight to active
        do_load(16'h1234, 4'b0000);
        enable = 1'b1;
        cycles(80);

        // leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0042, 4'b0000);
        cycles(70);
        do_load(16'h0000, 4'b0000);
        cycles(70);

        // last load before the boundary wins
        wait_pos(10);
        do_load(16'h1111, 4'b0000);
        cycles(5);
        do_load(16'h2222, 4'b0000);
        cycles(70);

        // invalid / hex nibbles with dp
        blank_lz = 1'b0;
        do_load(16'h5B3B, 4'b1011);
        cycles(70);

        // load exactly on the frame boundary
        wait_pos(FRAME - 1);
        do_load(16'h9876, 4'b0001);
        cycles(40);

        // randomized traffic
        for (int unsigned it = 0; it < 30; it++) begin
            logic [15:0] d;
            d = 16'($urandom);
            d = d >> (4 * $urandom_range(0, 4));
            blank_lz = 1'($urandom);
            cycles($urandom_range(1, 40));
            do_load(d, 4'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                cycles($urandom_range(1, 6));
                if ($urandom_range(0, 1) == 1) do_load(16'($urandom), 4'($urandom));
                enable = 1'b1;
            end
        end
        cycles(40);

        // disable mid-slot, re-enable, then asynchronous reset while lit
        wait_pos(20);
        enable = 1'b0;
        cycles(5);
        do_load(16'h0007, 4'b0001);
        enable = 1'b1;
        cycles(5);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg, an, frame_done} !== {8'hFF, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got seg=%h an=%b fd=%b want seg=ff an=1111 fd=0",
                     seg, an, frame_done);
        end
        #4 rst_n = 1'b1;
        cycles(1);
        cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
